// File: rtl/rotating_priority_arbiter.sv
// rotating_priority_arbiter
//
// N-way rotating-priority arbiter. A priority vector marks the starting slot
// (its lowest set bit). The first active request at or after that slot,
// wrapping modulo N, wins. Grant and any-grant are registered with one cycle
// of latency. No pointer state is kept here: the upstream controller rotates
// prio to achieve fairness.
//
// Ports:
//   clk       - system clock, rising-edge active
//   rst       - asynchronous, active-high reset; clears grant and any_grant
//   prio[N]   - priority vector; lowest set bit selects the start slot (0 if none)
//   req[N]    - request vector, one bit per requester
//   grant[N]  - registered one-hot grant, all zero when nothing is requested
//   any_grant - registered flag, high when any request was active
module rotating_priority_arbiter #(
    parameter int N = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] prio,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         any_grant
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] prio_low;
    logic [N-1:0] upper_mask;
    logic [N-1:0] masked;
    logic [N-1:0] pick;
    logic [N-1:0] next_grant;
    logic         next_any;

    always_comb begin
        // Isolate the lowest set bit of prio; extra set bits are ignored.
        prio_low   = prio & (~prio + ONE);
        // Thermometer of slots at or above the start slot. With prio == 0,
        // prio_low - 1 is all ones, the mask is empty and the fallback below
        // scans from slot 0, which is exactly the s = 0 behaviour.
        upper_mask = ~(prio_low - ONE);
        masked     = req & upper_mask;
        // Nothing requesting at/after the start slot: wrap to the lowest
        // requester overall (which is necessarily below the start slot).
        pick       = (|masked) ? masked : req;
        next_grant = pick & (~pick + ONE);
        next_any   = |req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant     <= '0;
            any_grant <= 1'b0;
        end else begin
            grant     <= next_grant;
            any_grant <= next_any;
        end
    end

endmodule

// File: tb/tb_rotating_priority_arbiter.sv
// tb_rotating_priority_arbiter
//
// Scoreboard bench for rotating_priority_arbiter (N = 128). Stimulus is
// applied on the falling edge and the expected registered response is queued;
// a monitor pops one entry per rising edge and compares the DUT outputs.
module tb_rotating_priority_arbiter;

    localparam int N = 128;

    logic         clk;
    logic         rst;
    logic [N-1:0] prio;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic         any_grant;

    typedef struct {
        logic [N-1:0] g;
        logic         a;
        int           id;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    bit   done   = 0;

    rotating_priority_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .prio      (prio),
        .req       (req),
        .grant     (grant),
        .any_grant (any_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] bitv(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Independent reference: explicit wrap-around scan from the start slot.
    function automatic logic [N-1:0] model(input logic [N-1:0] p, input logic [N-1:0] r);
        int s;
        s = 0;
        for (int k = N - 1; k >= 0; k--)
            if (p[k]) s = k;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (s + k) % N;
            if (r[idx]) return bitv(idx);
        end
        return '0;
    endfunction

    task automatic check(input string name, input int id,
                         input logic [N-1:0] got_g, input logic got_a,
                         input logic [N-1:0] exp_g, input logic exp_a);
        checks++;
        if (got_g === exp_g && got_a === exp_a) begin
            passes++;
        end else begin
            $display("FAIL %s #%0d: grant=%h any=%b, expected grant=%h any=%b",
                     name, id, got_g, got_a, exp_g, exp_a);
        end
    endtask

    // Drive one vector; the expected outputs appear after the next rising edge.
    task automatic apply(input logic [N-1:0] p, input logic [N-1:0] r,
                         input logic [N-1:0] eg, input logic ea, input int id);
        exp_t e;
        @(negedge clk);
        prio = p;
        req  = r;
        e.g  = eg;
        e.a  = ea;
        e.id = id;
        exp_q.push_back(e);
    endtask

    // Monitor: one queued expectation per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("vec", e.id, grant, any_grant, e.g, e.a);
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        int           budget;

        rst  = 1'b1;
        prio = '0;
        req  = '0;

        // Reset state while rst held across edges.
        repeat (2) @(posedge clk);
        #1 check("reset_hold", 0, grant, any_grant, '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Load a nonzero grant, then assert reset mid-cycle.
        apply(bitv(0), bitv(3), bitv(3), 1'b1, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check("reset_async", 2, grant, any_grant, '0, 1'b0);
        @(posedge clk);
        #1 check("reset_edge", 3, grant, any_grant, '0, 1'b0);
        #2 rst = 1'b0;
        #1 check("reset_release", 4, grant, any_grant, '0, 1'b0);

        // Directed vectors with hand-computed results.
        apply(bitv(0),   bitv(0)  | bitv(64),  bitv(0),   1'b1, 10);
        apply(bitv(10),  bitv(0)  | bitv(64),  bitv(64),  1'b1, 11);
        apply(bitv(64),  bitv(0)  | bitv(64),  bitv(64),  1'b1, 12);
        apply(bitv(65),  bitv(0)  | bitv(64),  bitv(0),   1'b1, 13);
        apply(bitv(127), bitv(5)  | bitv(69),  bitv(5),   1'b1, 14);
        apply(bitv(127), bitv(63) | bitv(127), bitv(127), 1'b1, 15);
        apply(bitv(42),  '0,                   '0,        1'b0, 16);
        apply(bitv(100), '1,                   bitv(100), 1'b1, 17);
        apply(bitv(127), bitv(126),            bitv(126), 1'b1, 18);
        apply(bitv(127), bitv(0),              bitv(0),   1'b1, 19);
        apply(bitv(50),  bitv(7)  | bitv(20),  bitv(7),   1'b1, 20);
        // Multiple prio bits: only the lowest (3) counts.
        apply(bitv(10) | bitv(3), bitv(1) | bitv(5), bitv(5), 1'b1, 21);
        // prio == 0 acts as start slot 0.
        apply('0, bitv(5)  | bitv(70), bitv(5),  1'b1, 22);
        apply('0, bitv(127),           bitv(127), 1'b1, 23);
        apply('0, '1,                  bitv(0),  1'b1, 24);
        apply('0, '0,                  '0,       1'b0, 25);

        // Sweep: every start slot against paired requests, plus idle.
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N / 2; j++) begin
                r = bitv(j) | bitv(j + N / 2);
                apply(bitv(i), r, model(bitv(i), r), 1'b1, 1000 + i * 64 + j);
            end
            apply(bitv(i), '0, '0, 1'b0, 100000 + i);
        end
        for (int j = 0; j < N / 2; j++) begin
            r = bitv(j) | bitv(j + N / 2);
            apply('0, r, model(bitv(0), r), 1'b1, 200000 + j);
        end

        // Drain the scoreboard with a bounded wait.
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rotating_priority_arbiter.md
Name: rotating_priority_arbiter

Overview:
- N-way rotating-priority (round-robin style) arbiter.
- A one-hot priority vector marks the starting slot. The lowest-index active request at or after that slot, wrapping modulo N, wins.
- The grant is one-hot, plus an any-grant flag. Both outputs are registered on a single clock.
- Sits between request sources and a shared resource. The upstream controller rotates the priority vector.

Parameters:
- N, 128, number of requesters; width of prio, req and grant. Legal range: N >= 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- prio  input  N  priority vector, normally one-hot; bit k marks slot k as highest priority.
- req  input  N  request vector; bit k = requester k is requesting.
- grant  output  N  registered one-hot grant; all zero when no grant.
- any_grant  output  1  registered; high when any request was active.

Behaviour:
- Reset:
  - While rst=1: grant=0 and any_grant=0, asynchronously and regardless of clk.
  - On rst deassertion the outputs hold 0 until the next rising clk edge.
- Start index s:
  - s = index of the lowest set bit of prio.
  - If prio=0, s=0.
  - If prio has multiple bits set, only the lowest set bit counts; higher set bits are ignored.
- Arbitration (combinational, from the current prio and req):
  - Scan indices s, s+1, …, N-1, 0, 1, …, s-1 (wrap-around).
  - The first index k with req[k]=1 is the winner.
  - next_grant = one-hot bit k.
  - next_any = |req.
  - If req=0: next_grant=0 and next_any=0.
- Registration:
  - On each rising clk edge with rst=0: grant<=next_grant and any_grant<=next_any.
  - Latency is exactly 1 cycle from input change to output.
  - No handshake and no internal pointer state. Fairness rotation is entirely the caller's job via prio.
- Invariants:
  - grant is always zero or one-hot.
  - any_grant == |grant.
  - A grant bit is only set where req was set in the sampled cycle.
- Boundaries:
  - Requester at slot s itself: granted immediately.
  - s = N-1 with no request at N-1: wraps to index 0 and upward.
  - All requests below s: the lowest-index requester below s wins.
  - req all ones: grant = bit s.
- Mid-operation: changing prio and req in the same cycle is fine; the edge samples both together. Reset asserted mid-operation clears the outputs immediately.
- Implementation:
  - Suggested structure: double-width masked priority encoding, (req & ~(prio-1)) with fallback to req, or an equivalent thermometer/carry-chain structure.
  - Must close timing at N=128 as pure combinational logic plus one register stage.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with req≠0 -> grant=0 and any_grant=0 at once; both stay 0 until the first edge after release.
- Basic: prio=bit0, req=bit0|bit64 -> after 1 edge, grant=bit0 and any_grant=1.
- Mid start: prio=bit10, req=bit0|bit64 -> grant=bit64. Then prio=bit64, same req -> grant=bit64. Then prio=bit65, same req -> grant=bit0 (wrap).
- Wrap at top: prio=bit127, req=bit5|bit69 -> grant=bit5. Then req=bit63|bit127 -> grant=bit127.
- Idle: any prio, req=0 -> grant=0 and any_grant=0. Then req=all ones with prio=bit100 -> grant=bit100.
- Exhaustive sweep: for every i in 0..127 set prio=bit i, for every j in 0..63 set req=bit j|bit(j+64), then req=0. Compare against a reference model: one-hot winner, any_grant=1 on requests and 0 on idle, 1-cycle latency. Also check prio=0 behaves as prio=bit0.
